// File: rtl/cpu_pkg.sv
// Shared CPU datapath widths and the write-back latch record.
package cpu_pkg;
    localparam int D = 8;
    localparam int A = 3;

    typedef struct packed {
        logic         valid;
        logic [A-1:0] addr;
        logic [D-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/rf_read_port.sv
// One register-file read port: priority mux over r0, live write, latched write and array.
module rf_read_port #(
    parameter int D          = cpu_pkg::D,
    parameter int A          = cpu_pkg::A,
    parameter bit ZERO_R0    = 1'b1,
    parameter bit BYPASS_NOW = 1'b0
) (
    input  logic [A-1:0] rd_addr_i,
    input  logic         wr_en_i,
    input  logic         stall_i,
    input  logic [A-1:0] wr_addr_i,
    input  logic [D-1:0] dat_in_i,
    input  logic         wb_valid_i,
    input  logic [A-1:0] wb_addr_i,
    input  logic [D-1:0] wb_data_i,
    input  logic [D-1:0] arr_data_i,
    output logic [D-1:0] rd_data_o
);
    always_comb begin
        rd_data_o = arr_data_i;
        if (ZERO_R0 && rd_addr_i == '0)
            rd_data_o = '0;
        else if (BYPASS_NOW && wr_en_i && !stall_i && wr_addr_i == rd_addr_i)
            rd_data_o = dat_in_i;
        else if (wb_valid_i && wb_addr_i == rd_addr_i)
            rd_data_o = wb_data_i;
    end
endmodule

// File: rtl/reg_file_wb.sv
// Register file with a 1-deep write-back latch in front of the array and two bypassing read ports.
module reg_file_wb #(
    parameter int D          = cpu_pkg::D,
    parameter int A          = cpu_pkg::A,
    parameter bit ZERO_R0    = 1'b1,
    parameter bit BYPASS_NOW = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [A-1:0] wr_addr,
    input  logic [D-1:0] dat_in,
    input  logic         stall,
    input  logic [A-1:0] rd_addrA,
    input  logic [A-1:0] rd_addrB,
    output logic [D-1:0] datA_out,
    output logic [D-1:0] datB_out,
    output logic         wb_busy
);
    import cpu_pkg::*;

    localparam int N = 1 << A;

    // Local record sized by this instance's parameters (cpu_pkg::wb_req_t is the default-width view).
    typedef struct packed {
        logic         valid;
        logic [A-1:0] addr;
        logic [D-1:0] data;
    } wb_lat_t;

    wb_lat_t      wb_q, wb_d;
    logic [D-1:0] arr_q [N];
    logic         commit;

    always_comb begin
        wb_d       = wb_q;
        wb_d.valid = wr_en;
        wb_d.addr  = wr_addr;
        wb_d.data  = dat_in;
    end

    assign commit = wb_q.valid && !(ZERO_R0 && wb_q.addr == '0);

    // Capture and commit share one edge so back-to-back writes sustain one per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_q <= '0;
            for (int i = 0; i < N; i++)
                arr_q[i] <= '0;
        end else if (!stall) begin
            wb_q <= wb_d;
            if (commit)
                arr_q[wb_q.addr] <= wb_q.data;
        end
    end

    assign wb_busy = wb_q.valid;

    logic [1:0][A-1:0] rd_addr;
    logic [1:0][D-1:0] rd_data;

    assign rd_addr  = {rd_addrB, rd_addrA};
    assign datA_out = rd_data[0];
    assign datB_out = rd_data[1];

    for (genvar p = 0; p < 2; p++) begin : g_rd
        rf_read_port #(
            .D         (D),
            .A         (A),
            .ZERO_R0   (ZERO_R0),
            .BYPASS_NOW(BYPASS_NOW)
        ) u_port (
            .rd_addr_i (rd_addr[p]),
            .wr_en_i   (wr_en),
            .stall_i   (stall),
            .wr_addr_i (wr_addr),
            .dat_in_i  (dat_in),
            .wb_valid_i(wb_q.valid),
            .wb_addr_i (wb_q.addr),
            .wb_data_i (wb_q.data),
            .arr_data_i(arr_q[rd_addr[p]]),
            .rd_data_o (rd_data[p])
        );
    end
endmodule

// File: tb/tb_reg_file_wb.sv
// Randomized + directed bench for reg_file_wb, two configurations against an architectural model.
module tb_reg_file_wb;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] dat_in = '0;
    logic       stall = 1'b0;
    logic [2:0] rd_addrA = '0, rd_addrB = '0;
    logic [7:0] datA0, datB0, datA1, datB1;
    logic       busy0, busy1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Default config: r0 hardwired zero, no live bypass.
    reg_file_wb #(.D(8), .A(3), .ZERO_R0(1'b1), .BYPASS_NOW(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
        .stall(stall), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
        .datA_out(datA0), .datB_out(datB0), .wb_busy(busy0));

    // Alternate config: r0 is an ordinary register, live write bypass enabled.
    reg_file_wb #(.D(8), .A(3), .ZERO_R0(1'b0), .BYPASS_NOW(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
        .stall(stall), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
        .datA_out(datA1), .datB_out(datB1), .wb_busy(busy1));

    // Architectural model: the value software sees is that of the last accepted write.
    logic [7:0] vis0 [8];
    logic [7:0] vis1 [8];
    logic       busy_m;
    bit         started = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                vis0[i] = 8'h00;
                vis1[i] = 8'h00;
            end
            busy_m  = 1'b0;
            started = 1;
        end else if (!stall) begin
            if (wr_en) begin
                if (wr_addr != 3'd0) vis0[wr_addr] = dat_in;
                vis1[wr_addr] = dat_in;
            end
            busy_m = wr_en;
        end
    end

    function automatic logic [7:0] exp0(input logic [2:0] a);
        return (a == 3'd0) ? 8'h00 : vis0[a];
    endfunction

    function automatic logic [7:0] exp1(input logic [2:0] a);
        return (wr_en && !stall && wr_addr == a) ? dat_in : vis1[a];
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("m0_A", datA0, exp0(rd_addrA));
            chk("m0_B", datB0, exp0(rd_addrB));
            chk("m0_busy", {7'd0, busy0}, {7'd0, busy_m});
            chk("m1_A", datA1, exp1(rd_addrA));
            chk("m1_B", datB1, exp1(rd_addrB));
            chk("m1_busy", {7'd0, busy1}, {7'd0, busy_m});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic we, input logic [2:0] wa, input logic [7:0] d);
        wr_en = we; wr_addr = wa; dat_in = d;
    endtask

    initial begin
        // Reset: 2 cycles low, every register reads 0.
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_addrA = 3'(i); rd_addrB = 3'(7 - i);
            #1;
            chk("rst_A", datA0, 8'h00);
            chk("rst_B1", datB1, 8'h00);
        end
        chk("rst_busy", {7'd0, busy0}, 8'h00);

        // r3 = A5: latch bypass the next cycle, array the cycle after.
        rd_addrA = 3'd3;
        drv(1, 3'd3, 8'hA5);
        tick();
        drv(0, 3'd0, 8'h00);
        #1;
        chk("wr_latch_A", datA0, 8'hA5);
        chk("wr_latch_busy", {7'd0, busy0}, 8'h01);
        tick();
        chk("wr_arr_A", datA0, 8'hA5);
        chk("wr_arr_busy", {7'd0, busy0}, 8'h00);

        // Back-to-back writes to r2.
        rd_addrA = 3'd2; rd_addrB = 3'd2;
        drv(1, 3'd2, 8'h11);
        tick();
        drv(1, 3'd2, 8'h22);
        #1;
        chk("b2b_first_A", datA0, 8'h11);
        chk("b2b_first_B", datB0, 8'h11);
        chk("b2b_live1", datA1, 8'h22);
        tick();
        drv(0, 3'd0, 8'h00);
        #1;
        chk("b2b_second_A", datA0, 8'h22);
        tick();
        chk("b2b_final_B", datB0, 8'h22);

        // Pending r4 write held across a stall; r5 write during stall is dropped.
        rd_addrA = 3'd4; rd_addrB = 3'd5;
        drv(1, 3'd4, 8'h66);
        tick();
        stall = 1'b1;
        drv(1, 3'd5, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_busy", {7'd0, busy0}, 8'h01);
            chk("stall_r4", datA0, 8'h66);
            chk("stall_r5", datB1, 8'h00);
        end
        stall = 1'b0;
        drv(0, 3'd0, 8'h00);
        tick();
        chk("unstall_busy", {7'd0, busy0}, 8'h00);
        chk("unstall_r4", datA0, 8'h66);
        chk("unstall_r5", datB0, 8'h00);

        // r0 write under ZERO_R0.
        rd_addrA = 3'd0; rd_addrB = 3'd0;
        drv(1, 3'd0, 8'hFF);
        #1;
        chk("r0_now_A", datA0, 8'h00);
        tick();
        drv(0, 3'd0, 8'h00);
        #1;
        chk("r0_lat_A", datA0, 8'h00);
        chk("r0_lat_B", datB0, 8'h00);
        chk("r0_busy", {7'd0, busy0}, 8'h01);
        chk("r0_dut1", datA1, 8'hFF);
        tick();
        chk("r0_arr_B", datB0, 8'h00);

        // Reset right after writing r1 drops the latched write.
        rd_addrA = 3'd1;
        drv(1, 3'd1, 8'h77);
        tick();
        drv(0, 3'd0, 8'h00);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_mid_A", datA0, 8'h00);
        chk("rst_mid_A1", datA1, 8'h00);
        chk("rst_mid_busy", {7'd0, busy0}, 8'h00);
        tick();
        chk("rst_mid_A_late", datA0, 8'h00);

        // Random traffic, model checks every cycle.
        for (int c = 0; c < 600; c++) begin
            drv(1'($urandom_range(0, 99) < 60), 3'($urandom), 8'($urandom));
            stall    = ($urandom_range(0, 99) < 20);
            rst_n    = !($urandom_range(0, 99) < 2);
            rd_addrA = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom);
            rd_addrB = ($urandom_range(0, 3) == 0) ? rd_addrA : 3'($urandom);
            tick();
        end

        #10;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
